// File: rtl/pipelined_adder_pkg.sv
// Shared ALU definitions: default datapath width and the add/subtract op encoding.
package alu_pkg;

    localparam int   DATA_W = 32;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result bus of the pipelined add/subtract unit.
interface pipelined_adder_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             sub;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, in1, in2, sub, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, zero
    );

    modport slave (
        input  in_valid, in1, in2, sub, carry_in, out_ready,
        output in_ready, out_valid, sum, carry, overflow, zero
    );

endinterface

// File: rtl/pipelined_adder_segment.sv
// Combinational SEG-bit carry-lookahead adder; one instance resolves one pipeline segment.
module adder_segment #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           cin_i,
    output logic [SEG-1:0] sum_o,
    output logic           cout_o,
    output logic           c_msb_in_o
);

    logic [SEG-1:0] genBits;
    logic [SEG-1:0] propBits;
    logic [SEG:0]   carries;
    logic           propChain;
    logic           carryAcc;

    // Each carry is the flat OR of generate terms gated by the propagate chain above them.
    always_comb begin
        genBits   = a_i & b_i;
        propBits  = a_i ^ b_i;
        carries   = '0;
        propChain = 1'b1;
        carryAcc  = 1'b0;
        carries[0] = cin_i;
        for (int i = 0; i < SEG; i++) begin
            propChain = 1'b1;
            carryAcc  = 1'b0;
            for (int j = i; j >= 0; j--) begin
                carryAcc  = carryAcc | (propChain & genBits[j]);
                propChain = propChain & propBits[j];
            end
            carries[i+1] = carryAcc | (propChain & cin_i);
        end
        sum_o      = propBits ^ carries[SEG-1:0];
        cout_o     = carries[SEG];
        c_msb_in_o = carries[SEG-1];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: one lookahead segment per stage, registered carry between stages,
// valid/ready handshake with a global stall on backpressure.
module pipelined_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SEG   = 16
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);

    localparam int               STAGES   = WIDTH / SEG;
    localparam logic [WIDTH-1:0] SEG_MASK = {WIDTH{1'b1}} >> (WIDTH - SEG);

    logic              advance;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              overflow_q;
    logic              overflow_d;

    assign advance = ~valid_q[STAGES-1] | bus.out_ready;

    // B is inverted and the carry-in resolved at entry, so the op travels as plain operands.
    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        logic [WIDTH-1:0] aIn;
        logic [WIDTH-1:0] bIn;
        logic [WIDTH-1:0] sumIn;
        logic             cIn;
        logic [SEG-1:0]   segSum;
        logic             segCout;
        logic             segCmsb;

        if (k == 0) begin : gen_entry
            assign aIn        = bus.in1;
            assign bIn        = (bus.sub == OP_ADD) ? bus.in2 : ~bus.in2;
            assign cIn        = (bus.sub == OP_SUB) | bus.carry_in;
            assign sumIn      = '0;
            assign valid_d[k] = bus.in_valid;
        end else begin : gen_chain
            assign aIn        = a_q[k-1];
            assign bIn        = b_q[k-1];
            assign cIn        = carry_q[k-1];
            assign sumIn      = sum_q[k-1];
            assign valid_d[k] = valid_q[k-1];
        end

        adder_segment #(
            .SEG (SEG)
        ) u_segment (
            .a_i        (aIn[k*SEG +: SEG]),
            .b_i        (bIn[k*SEG +: SEG]),
            .cin_i      (cIn),
            .sum_o      (segSum),
            .cout_o     (segCout),
            .c_msb_in_o (segCmsb)
        );

        assign a_d[k]     = aIn;
        assign b_d[k]     = bIn;
        assign carry_d[k] = segCout;
        assign sum_d[k]   = (sumIn & ~(SEG_MASK << (k*SEG))) | (WIDTH'(segSum) << (k*SEG));

        if (k == STAGES - 1) begin : gen_last
            assign overflow_d = segCmsb ^ segCout;
        end
    end

    // Every stage shifts together or holds together; no bubble squeezing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            carry_q    <= '0;
            overflow_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q    <= valid_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.carry     = carry_q[STAGES-1];
    assign bus.overflow  = overflow_q;
    assign bus.zero      = (sum_q[STAGES-1] == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at 32/16, 64/16 and 8/8: directed cases, latency, a random
// backpressured stream against a plain-arithmetic model, and reset mid-stream.
module tb_pipelined_adder;
    import alu_pkg::*;

    typedef struct packed {
        logic [63:0] sum;
        logic        carry;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   assertCount = 0;
    int   failCount = 0;
    res_t qA[$];
    res_t qB[$];
    res_t qC[$];
    int   accA = 0, accB = 0, accC = 0;
    int   outA = 0, outB = 0, outC = 0;
    logic stallA = 1'b0;
    res_t holdA;
    res_t eA, eB, eC;

    pipelined_adder_if #(.WIDTH(32)) ifA ();
    pipelined_adder_if #(.WIDTH(64)) ifB ();
    pipelined_adder_if #(.WIDTH(8))  ifC ();

    pipelined_adder #(.WIDTH(32), .SEG(16)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    pipelined_adder #(.WIDTH(64), .SEG(16)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
    pipelined_adder #(.WIDTH(8),  .SEG(8))  dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-precision sum truncated to w bits; overflow from operand/result signs.
    function automatic res_t refModel(input logic [63:0] a, input logic [63:0] b,
                                      input logic sub, input logic cin, input int w);
        logic [64:0] mask;
        logic [64:0] bEff;
        logic [64:0] full;
        res_t        r;
        mask   = (65'd1 << w) - 65'd1;
        bEff   = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        full   = ({1'b0, a} & mask) + bEff + (sub ? 65'd1 : {64'd0, cin});
        r.sum  = full[63:0] & mask[63:0];
        r.carry = full[w];
        r.ovf  = (a[w-1] == bEff[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        assertCount++;
        assert (obs === expv)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic setReady(input logic r);
        ifA.out_ready = r;
        ifB.out_ready = r;
        ifC.out_ready = r;
    endtask

    task automatic applyStimulus(input logic v);
        ifA.in_valid = v;
        ifB.in_valid = v;
        ifC.in_valid = v;
        ifA.in1 = $urandom;
        ifA.in2 = $urandom;
        ifA.sub = 1'($urandom_range(0, 1));
        ifA.carry_in = 1'($urandom_range(0, 1));
        ifB.in1 = {$urandom, $urandom};
        ifB.in2 = {$urandom, $urandom};
        ifB.sub = 1'($urandom_range(0, 1));
        ifB.carry_in = 1'($urandom_range(0, 1));
        ifC.in1 = 8'($urandom);
        ifC.in2 = 8'($urandom);
        ifC.sub = 1'($urandom_range(0, 1));
        ifC.carry_in = 1'($urandom_range(0, 1));
    endtask

    task automatic sendA(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic cin, output int lat);
        int start;
        @(posedge clk); #1;
        ifA.in1 = a;
        ifA.in2 = b;
        ifA.sub = sub;
        ifA.carry_in = cin;
        ifA.in_valid = 1'b1;
        start = cyc;
        @(posedge clk); #1;
        ifA.in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifA.out_valid) begin
                lat = cyc - start;
                break;
            end
        end
    endtask

    // Scoreboard for the 32-bit unit, including output stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            qA.delete();
            stallA = 1'b0;
        end else begin
            if (stallA) begin
                checkVal("A stall out_valid", 64'(ifA.out_valid), 64'd1);
                checkVal("A stall sum", 64'(ifA.sum), holdA.sum);
                checkVal("A stall carry", 64'(ifA.carry), 64'(holdA.carry));
                checkVal("A stall overflow", 64'(ifA.overflow), 64'(holdA.ovf));
            end
            if (ifA.out_valid && ifA.out_ready) begin
                if (qA.size() == 0) begin
                    checkVal("A unexpected output", 64'(ifA.out_valid), 64'd0);
                end else begin
                    eA = qA.pop_front();
                    outA++;
                    checkVal("A sum", 64'(ifA.sum), eA.sum);
                    checkVal("A carry", 64'(ifA.carry), 64'(eA.carry));
                    checkVal("A overflow", 64'(ifA.overflow), 64'(eA.ovf));
                    checkVal("A zero", 64'(ifA.zero), 64'(eA.sum == 64'd0));
                end
            end
            if (ifA.in_valid && ifA.in_ready) begin
                qA.push_back(refModel(64'(ifA.in1), 64'(ifA.in2), ifA.sub, ifA.carry_in, 32));
                accA++;
            end
            stallA = ifA.out_valid && !ifA.out_ready;
            holdA.sum = 64'(ifA.sum);
            holdA.carry = ifA.carry;
            holdA.ovf = ifA.overflow;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qB.delete();
        end else begin
            if (ifB.out_valid && ifB.out_ready) begin
                if (qB.size() == 0) begin
                    checkVal("B unexpected output", 64'(ifB.out_valid), 64'd0);
                end else begin
                    eB = qB.pop_front();
                    outB++;
                    checkVal("B sum", ifB.sum, eB.sum);
                    checkVal("B carry", 64'(ifB.carry), 64'(eB.carry));
                    checkVal("B overflow", 64'(ifB.overflow), 64'(eB.ovf));
                    checkVal("B zero", 64'(ifB.zero), 64'(eB.sum == 64'd0));
                end
            end
            if (ifB.in_valid && ifB.in_ready) begin
                qB.push_back(refModel(ifB.in1, ifB.in2, ifB.sub, ifB.carry_in, 64));
                accB++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qC.delete();
        end else begin
            if (ifC.out_valid && ifC.out_ready) begin
                if (qC.size() == 0) begin
                    checkVal("C unexpected output", 64'(ifC.out_valid), 64'd0);
                end else begin
                    eC = qC.pop_front();
                    outC++;
                    checkVal("C sum", 64'(ifC.sum), eC.sum);
                    checkVal("C carry", 64'(ifC.carry), 64'(eC.carry));
                    checkVal("C overflow", 64'(ifC.overflow), 64'(eC.ovf));
                    checkVal("C zero", 64'(ifC.zero), 64'(eC.sum == 64'd0));
                end
            end
            if (ifC.in_valid && ifC.in_ready) begin
                qC.push_back(refModel(64'(ifC.in1), 64'(ifC.in2), ifC.sub, ifC.carry_in, 8));
                accC++;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   lat, start, latA, latB, latC;
        int   baseAcc, baseOut;

        vecs[0] = '{32'h0000FFFF, 32'h00000001, OP_ADD, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, OP_ADD, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, OP_ADD, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'h00000005, 32'h00000007, OP_SUB, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h00000007, 32'h00000005, OP_SUB, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h80000000, 32'h00000001, OP_SUB, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{32'h00000001, 32'h00000001, OP_ADD, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0};

        // Reset held with valid inputs present must produce nothing.
        rst_n = 1'b0;
        setReady(1'b1);
        applyStimulus(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("reset A out_valid", 64'(ifA.out_valid), 64'd0);
        checkVal("reset A sum", 64'(ifA.sum), 64'd0);
        checkVal("reset A carry", 64'(ifA.carry), 64'd0);
        checkVal("reset A overflow", 64'(ifA.overflow), 64'd0);
        checkVal("reset A in_ready", 64'(ifA.in_ready), 64'd1);
        checkVal("reset B out_valid", 64'(ifB.out_valid), 64'd0);
        checkVal("reset C out_valid", 64'(ifC.out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1'b0);
        $display("[TB] reset released at cycle %0d", cyc);

        foreach (vecs[i]) begin
            sendA(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat);
            checkVal($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
            checkVal($sformatf("vec%0d sum", i), 64'(ifA.sum), 64'(vecs[i].sum));
            checkVal($sformatf("vec%0d carry", i), 64'(ifA.carry), 64'(vecs[i].carry));
            checkVal($sformatf("vec%0d overflow", i), 64'(ifA.overflow), 64'(vecs[i].ovf));
            checkVal($sformatf("vec%0d zero", i), 64'(ifA.zero), 64'(vecs[i].zero));
        end

        // Latency of all three configurations from a single accepted op each.
        @(posedge clk); #1;
        applyStimulus(1'b1);
        start = cyc;
        @(posedge clk); #1;
        applyStimulus(1'b0);
        latA = -1;
        latB = -1;
        latC = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifA.out_valid && latA < 0) latA = cyc - start;
            if (ifB.out_valid && latB < 0) latB = cyc - start;
            if (ifC.out_valid && latC < 0) latC = cyc - start;
        end
        checkVal("latency 32/16", 64'(latA), 64'd2);
        checkVal("latency 64/16", 64'(latB), 64'd4);
        checkVal("latency 8/8", 64'(latC), 64'd1);

        // Random backpressured stream on all three units.
        baseAcc = accA;
        baseOut = outA;
        for (int n = 0; n < 3000 && (accA - baseAcc) < 100; n++) begin
            @(posedge clk); #1;
            setReady($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 4) != 0);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0);
        setReady(1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkVal("stream A accepted", 64'((accA - baseAcc) >= 100), 64'd1);
        checkVal("stream A in/out count", 64'(outA - baseOut), 64'(accA - baseAcc));
        checkVal("stream A drained", 64'(qA.size()), 64'd0);
        checkVal("stream B drained", 64'(qB.size()), 64'd0);
        checkVal("stream C drained", 64'(qC.size()), 64'd0);
        checkVal("stream B count", 64'(outB), 64'(accB));
        checkVal("stream C count", 64'(outC), 64'(accC));

        // Fill the pipes under backpressure, then reset: in-flight ops must vanish.
        @(posedge clk); #1;
        setReady(1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        applyStimulus(1'b0);
        setReady(1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkVal("post-reset A out_valid", 64'(ifA.out_valid), 64'd0);
            checkVal("post-reset B out_valid", 64'(ifB.out_valid), 64'd0);
            checkVal("post-reset C out_valid", 64'(ifC.out_valid), 64'd0);
        end

        sendA(32'd3, 32'd4, OP_ADD, 1'b0, lat);
        checkVal("after reset latency", 64'(lat), 64'd2);
        checkVal("after reset sum", 64'(ifA.sum), 64'd7);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
